// File: rtl/alu_operand_stage.sv
// Operand/opcode holding stage in front of the ALU, with a registered result and valid/ready output.
// Optional accumulator chaining (result written back into operand A) is enabled by ALU_ACC_FEEDBACK_EN.
module alu_operand_stage #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  ld_a,
    input  logic                  ld_b,
    input  logic [4:0]            op_in,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [4:0]            alu_opcode,
    input  logic [DATA_WIDTH-1:0] alu_c,
    input  logic [3:0]            alu_status,
    output logic [DATA_WIDTH-1:0] result,
    output logic [3:0]            flags,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  busy
);

    // Handshake: result/flags are presented while result_valid is high and are held
    // unchanged until a rising edge sees result_valid & result_ready, which is the transfer.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_alu_a;
    logic [DATA_WIDTH-1:0] r_alu_b;
    logic [4:0]            r_alu_opcode;
    logic [DATA_WIDTH-1:0] r_result;
    logic [3:0]            r_flags;
    logic                  r_result_valid;

    logic                  w_load_a;
    logic                  w_load_b;
    logic                  w_issue;
    logic                  w_capture;
    logic                  w_xfer;
    logic                  w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_DONE;
            S_DONE:  if (r_result_valid && result_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Strobes are qualified by state so bus activity outside IDLE never reaches the registers.
    always_comb begin
        w_load_a  = 1'b0;
        w_load_b  = 1'b0;
        w_issue   = 1'b0;
        w_capture = 1'b0;
        w_xfer    = 1'b0;
        w_busy    = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_load_a = ld_a;
                w_load_b = ld_b;
                w_issue  = start;
                w_busy   = 1'b0;
            end
            S_EXEC:  w_capture = 1'b1;
            S_DONE:  w_xfer = r_result_valid && result_ready;
            default: w_busy = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a <= '0;
        end else if (w_load_a) begin
            r_alu_a <= data_in;
`ifdef ALU_ACC_FEEDBACK_EN
        end else if (w_xfer) begin
            r_alu_a <= r_result;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_b      <= '0;
            r_alu_opcode <= '0;
        end else begin
            if (w_load_b) r_alu_b <= data_in;
            if (w_issue)  r_alu_opcode <= op_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result       <= '0;
            r_flags        <= '0;
            r_result_valid <= 1'b0;
        end else if (w_capture) begin
            r_result       <= alu_c;
            r_flags        <= alu_status;
            r_result_valid <= 1'b1;
        end else if (w_xfer) begin
            r_result_valid <= 1'b0;
        end
    end

    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_opcode   = r_alu_opcode;
    assign result       = r_result;
    assign flags        = r_flags;
    assign result_valid = r_result_valid;
    assign busy         = w_busy;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed cases plus randomized operations,
// scoreboarded against an operand/ALU reference model (honours ALU_ACC_FEEDBACK_EN).
module tb_alu_operand_stage;
  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          ld_a;
  logic          ld_b;
  logic [4:0]    op_in;
  logic          start;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [4:0]    alu_opcode;
  logic [DW-1:0] alu_c;
  logic [3:0]    alu_status;
  logic [DW-1:0] result;
  logic [3:0]    flags;
  logic          result_valid;
  logic          result_ready;
  logic          busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW+3:0] exp_q[$];
  logic [DW-1:0] m_a;
  logic [DW-1:0] m_b;
  logic [4:0]    m_op;

  alu_operand_stage #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .ld_a(ld_a), .ld_b(ld_b),
    .op_in(op_in), .start(start), .alu_a(alu_a), .alu_b(alu_b),
    .alu_opcode(alu_opcode), .alu_c(alu_c), .alu_status(alu_status),
    .result(result), .flags(flags), .result_valid(result_valid),
    .result_ready(result_ready), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ALU behaviour: returns {status, result}; status = {sign, zero, parity, carry}
  function automatic logic [DW+3:0] alu_fn(input logic [4:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [DW:0]   w;
    logic [DW-1:0] c;
    logic          cy;
    case (op)
      5'd1:    w = {1'b0, a} + 1;
      5'd2:    w = {1'b0, a} + {1'b0, b};
      5'd3:    w = {1'b0, a & b};
      5'd4:    w = {1'b0, a | b};
      5'd5:    w = {1'b0, a} - {1'b0, b};
      5'd6:    w = {1'b0, a ^ b};
      default: w = {1'b0, a};
    endcase
    c  = w[DW-1:0];
    cy = (op == 5'd5) ? (a >= b) : w[DW];
    return {c[DW-1], (c == '0), ^c, cy, c};
  endfunction

  always_comb {alu_status, alu_c} = alu_fn(alu_opcode, alu_a, alu_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(result_valid), 32'd0);
      end else begin
        check("result_flags", 32'({flags, result}), 32'(exp_q[0]));
        if (result_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic idle_inputs();
    ld_a = 1'b0; ld_b = 1'b0; start = 1'b0; data_in = '0; op_in = '0;
  endtask

  task automatic load(input logic la, input logic lb, input logic [DW-1:0] d);
    ld_a = la; ld_b = lb; data_in = d;
    @(posedge clk);
    if (la) m_a = d;
    if (lb) m_b = d;
    #1;
    idle_inputs();
  endtask

  task automatic run_op(input logic la, input logic lb, input logic [DW-1:0] d,
                        input logic [4:0] op, input int stall);
    logic [DW+3:0] e;
    bit            done;
    ld_a = la; ld_b = lb; data_in = d; op_in = op; start = 1'b1;
    result_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    if (la) m_a = d;
    if (lb) m_b = d;
    m_op = op;
    e = alu_fn(m_op, m_a, m_b);
    exp_q.push_back(e);
    #1;
    check("exec_busy", 32'(busy), 32'd1);
    check("exec_no_valid", 32'(result_valid), 32'd0);
    // junk on the control inputs while the operation is in flight must be ignored
    ld_a = 1'($urandom_range(0, 1)); ld_b = 1'($urandom_range(0, 1));
    start = 1'($urandom_range(0, 1)); data_in = DW'($urandom); op_in = 5'($urandom);
    result_ready = (stall == 0);
    @(posedge clk);
    #1;
    check("valid_latency", 32'(result_valid), 32'd1);
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      ld_a = 1'($urandom_range(0, 1)); ld_b = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1)); data_in = DW'($urandom);
      result_ready = (k >= stall);
      @(posedge clk);
      if (result_ready) begin
        done = 1'b1;
`ifdef ALU_ACC_FEEDBACK_EN
        m_a = e[DW-1:0];
`endif
      end
      #1;
    end
    if (!done) check("handshake_timeout", 32'd0, 32'd1);
    idle_inputs();
    result_ready = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(result_valid), 32'd0);
    check("hold_alu_a", 32'(alu_a), 32'(m_a));
    check("hold_alu_b", 32'(alu_b), 32'(m_b));
    check("hold_opcode", 32'(alu_opcode), 32'(m_op));
    check("result_kept", 32'({flags, result}), 32'(e));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    check({tag, "_opcode"}, 32'(alu_opcode), 32'd0);
    check({tag, "_result"}, 32'({flags, result}), 32'd0);
    check({tag, "_valid"}, 32'(result_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    result_ready = 1'b0;
    idle_inputs();
    m_a = '0; m_b = '0; m_op = '0;
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD 5 + 3
    load(1'b1, 1'b0, 8'h05);
    run_op(1'b0, 1'b1, 8'h03, 5'd2, 0);
    check("add_5_3", 32'({flags, result}), 32'h208);

    // SUB 5 - 5 with both operands loaded in one cycle alongside start
    run_op(1'b1, 1'b1, 8'h05, 5'd5, 0);
    check("sub_5_5", 32'({flags, result}), 32'h500);

    // long stall with junk inputs while waiting
    run_op(1'b1, 1'b0, 8'h33, 5'd2, 5);

    // load and start in the same cycle: INC 0x7F
    run_op(1'b1, 1'b0, 8'h7F, 5'd1, 0);
    check("inc_7f", 32'({flags, result}), 32'hA80);

    // asynchronous reset in the middle of EXEC
    data_in = 8'h11; ld_a = 1'b1; op_in = 5'd2; start = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    m_a = '0; m_b = '0; m_op = '0;
    @(posedge clk); #1;
    check("midreset_held_valid", 32'(result_valid), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("post_reset");
    run_op(1'b1, 1'b1, 8'h21, 5'd2, 1);
    check("post_reset_add", 32'({flags, result}), 32'h042);

    // accumulator chaining: three INCs starting from 0xFE
    load(1'b1, 1'b0, 8'hFE);
    run_op(1'b0, 1'b0, 8'h00, 5'd1, 0);
    check("chain_1", 32'(result), 32'hFF);
    run_op(1'b0, 1'b0, 8'h00, 5'd1, 0);
`ifdef ALU_ACC_FEEDBACK_EN
    check("chain_2", 32'({flags, result}), 32'h500);
    run_op(1'b0, 1'b0, 8'h00, 5'd1, 0);
    check("chain_3", 32'(result), 32'h01);
`else
    check("chain_2", 32'(result), 32'hFF);
    run_op(1'b0, 1'b0, 8'h00, 5'd1, 0);
    check("chain_3", 32'(result), 32'hFF);
`endif

    // randomized operations
    for (int i = 0; i < 60; i++) begin
      int pre;
      pre = $urandom_range(0, 2);
      for (int j = 0; j < pre; j++)
        load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom));
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom),
             5'($urandom_range(0, 7)), $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got 0 expected 1");
    $fatal(1);
  end

endmodule
